// File: rtl/dq_write_sequencer.sv
// DDR3 byte-lane write burst sequencer: takes one BL8 burst per handshake and emits per-cycle
// 4-beat nibbles, DM, DQS and tristate controls for the OSERDES, with DQS pre/postamble.
module dq_write_sequencer #(
  parameter int LANES      = 8,
  parameter int PRE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [8*LANES-1:0]   wr_data,
  input  logic [7:0]           wr_mask,
  output logic [4*LANES-1:0]   dq_data,
  output logic [3:0]           dm_data,
  output logic [3:0]           dqs_data,
  output logic                 dq_tri,
  output logic                 dqs_tri,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_BEAT0,
    S_BEAT1,
    S_POST
  } state_e;

  localparam logic [3:0] DQS_TOGGLE = 4'b0101;

  state_e               state_q, state_d;
  logic [1:0]           pre_cnt_q, pre_cnt_d;
  logic [8*LANES-1:0]   data_q, data_d;
  logic [7:0]           mask_q, mask_d;

  logic                 wr_ready_q, wr_ready_d;
  logic [4*LANES-1:0]   dq_data_q, dq_data_d;
  logic [3:0]           dm_data_q, dm_data_d;
  logic [3:0]           dqs_data_q, dqs_data_d;
  logic                 dq_tri_q, dq_tri_d;
  logic                 dqs_tri_q, dqs_tri_d;
  logic                 busy_q, busy_d;

  logic                 accept;
  logic [4*LANES-1:0]   nib_lo, nib_hi;

  assign accept = wr_valid & wr_ready_q;

  // State register: state, preamble counter, burst holding register and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      // NOTE: the holding register is a handful of flops, so it is reset too; this keeps X off
      // the pins in simulation and costs nothing worth avoiding.
      data_q     <= '0;
      mask_q     <= '0;
      wr_ready_q <= 1'b0;
      dq_data_q  <= '0;
      dm_data_q  <= '0;
      dqs_data_q <= '0;
      dq_tri_q   <= 1'b1;
      dqs_tri_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      wr_ready_q <= wr_ready_d;
      dq_data_q  <= dq_data_d;
      dm_data_q  <= dm_data_d;
      dqs_data_q <= dqs_data_d;
      dq_tri_q   <= dq_tri_d;
      dqs_tri_q  <= dqs_tri_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; the burst is captured only on the accepting edge.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    data_d    = accept ? wr_data : data_q;
    mask_d    = accept ? wr_mask : mask_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_PRE;
          pre_cnt_d = 2'(PRE_CYCLES - 1);
        end
      end
      S_PRE: begin
        if (pre_cnt_q == 2'd0) begin
          state_d = S_BEAT0;
        end else begin
          pre_cnt_d = pre_cnt_q - 2'd1;
        end
      end
      S_BEAT0: state_d = S_BEAT1;
      S_BEAT1: state_d = accept ? S_BEAT0 : S_POST;
      S_POST: begin
        if (accept) begin
          state_d   = S_PRE;
          pre_cnt_d = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat-major burst reshuffled into per-lane nibbles, earliest beat in bit 0.
  always_comb begin
    nib_lo = '0;
    nib_hi = '0;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < LANES; l++) begin
        nib_lo[4*l+k] = data_d[LANES*k+l];
        nib_hi[4*l+k] = data_d[LANES*(k+4)+l];
      end
    end
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    wr_ready_d = 1'b0;
    busy_d     = 1'b1;
    dq_tri_d   = 1'b1;
    dqs_tri_d  = 1'b1;
    dq_data_d  = '0;
    dm_data_d  = '0;
    dqs_data_d = '0;
    case (state_d)
      S_IDLE: begin
        wr_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      S_PRE: begin
        dqs_tri_d = 1'b0;
      end
      S_BEAT0: begin
        dq_tri_d   = 1'b0;
        dqs_tri_d  = 1'b0;
        dq_data_d  = nib_lo;
        dm_data_d  = mask_d[3:0];
        dqs_data_d = DQS_TOGGLE;
      end
      S_BEAT1: begin
        wr_ready_d = 1'b1;
        dq_tri_d   = 1'b0;
        dqs_tri_d  = 1'b0;
        dq_data_d  = nib_hi;
        dm_data_d  = mask_d[7:4];
        dqs_data_d = DQS_TOGGLE;
      end
      S_POST: begin
        wr_ready_d = 1'b1;
        dqs_tri_d  = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign wr_ready = wr_ready_q;
  assign dq_data  = dq_data_q;
  assign dm_data  = dm_data_q;
  assign dqs_data = dqs_data_q;
  assign dq_tri   = dq_tri_q;
  assign dqs_tri  = dqs_tri_q;
  assign busy     = busy_q;

endmodule
